// File: rtl/gcd_scheduler.sv
// gcd_scheduler: round-robin arbiter sharing one subtractive GCD engine among NREQ requesters
//
// Ports:
//   Clk      in   clock, rising edge
//   Reset_n  in   asynchronous active-low reset
//   Req      in   per-requester request level
//   X_in     in   operand X, requester i at [i*WIDTH +: WIDTH]
//   Y_in     in   operand Y, same packing as X_in
//   Grant    out  registered one-hot owner of the engine
//   Busy     out  engine not idle
//   Done     out  one-cycle result strobe
//   Done_id  out  requester index of the current/last result
//   Gcd_out  out  result, held until the next Done
module gcd_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic [NREQ-1:0]       Req,
   input  logic [NREQ*WIDTH-1:0] X_in,
   input  logic [NREQ*WIDTH-1:0] Y_in,
   output logic [NREQ-1:0]       Grant,
   output logic                  Busy,
   output logic                  Done,
   output logic [IDW-1:0]        Done_id,
   output logic [WIDTH-1:0]      Gcd_out
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam logic [IDW:0] N1 = (IDW+1)'(NREQ);
   state_t state_q, state_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [IDW-1:0]   ptr_q, ptr_d, id_q, id_d, win, idx;
   logic [WIDTH-1:0] xr_q, xr_d, yr_q, yr_d, gcd_q, gcd_d;
   logic [IDW:0]     s, s_w;
   logic             found, own_req;
   logic [WIDTH-1:0] xa [NREQ];
   logic [WIDTH-1:0] ya [NREQ];
   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign xa[i] = X_in[i*WIDTH +: WIDTH];
      assign ya[i] = Y_in[i*WIDTH +: WIDTH];
   end
   // first requester at or after ptr_q, wrapping modulo NREQ
   always_comb begin
      win   = '0;
      found = 1'b0;
      s     = '0;
      s_w   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         s   = {1'b0, ptr_q} + (IDW+1)'(k);
         s_w = (s >= N1) ? s - N1 : s;
         idx = s_w[IDW-1:0];
         if (!found && Req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end
   assign own_req = |(Req & grant_q);
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         grant_q <= '0;
         ptr_q   <= '0;
         id_q    <= '0;
         xr_q    <= '0;
         yr_q    <= '0;
         gcd_q   <= '0;
      end else begin
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         xr_q    <= xr_d;
         yr_q    <= yr_d;
         gcd_q   <= gcd_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = found ? CALC : IDLE;
         CALC:    state_d = !own_req ? IDLE :
                            (xr_q == '0 || yr_q == '0 || xr_q == yr_q) ? DONE : CALC;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      grant_d = grant_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      xr_d    = xr_q;
      yr_d    = yr_q;
      gcd_d   = gcd_q;
      case (state_q)
         IDLE: begin
            grant_d = found ? NREQ'(1) << win : '0;
            if (found) begin
               xr_d  = xa[win];
               yr_d  = ya[win];
               id_d  = win;
               ptr_d = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
            end
         end
         CALC: begin
            // abort takes priority so a dropped request never yields a result
            if (!own_req) grant_d = '0;
            else if (xr_q == '0 || yr_q == '0) gcd_d = '0;
            else if (xr_q == yr_q) gcd_d = xr_q;
            else if (xr_q < yr_q) yr_d = yr_q - xr_q;
            else xr_d = xr_q - yr_q;
         end
         default: grant_d = '0;
      endcase
   end
   always_comb begin
      Grant   = grant_q;
      Busy    = state_q != IDLE;
      Done    = state_q == DONE;
      Done_id = id_q;
      Gcd_out = gcd_q;
   end
endmodule

// File: tb/tb_gcd_scheduler.sv
// tb_gcd_scheduler: directed table-driven bench for gcd_scheduler
module tb_gcd_scheduler;
   localparam int NREQ = 4, WIDTH = 8, IDW = 2;
   logic                  Clk, Reset_n;
   logic [NREQ-1:0]       Req, Grant;
   logic [NREQ*WIDTH-1:0] X_in, Y_in;
   logic                  Busy, Done;
   logic [IDW-1:0]        Done_id;
   logic [WIDTH-1:0]      Gcd_out;
   int checks = 0, failures = 0;
   gcd_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .X_in(X_in), .Y_in(Y_in),
      .Grant(Grant), .Busy(Busy), .Done(Done), .Done_id(Done_id), .Gcd_out(Gcd_out)
   );
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   typedef struct {
      int         id;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] g;
      int         lat;
   } vec_t;
   vec_t vecs [8];
   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask
   task automatic do_reset();
      Reset_n = 1'b0;
      Req = '0;
      repeat (2) @(posedge Clk);
      @(negedge Clk) Reset_n = 1'b1;
      @(posedge Clk);
      #1;
   endtask
   // latency counts rising edges from the sampling edge (1) to the edge after which Done is high
   task automatic run(input int id, input logic [7:0] x, input logic [7:0] y,
                      output int lat, output logic [7:0] g, output int gid, output bit bad);
      X_in[id*WIDTH +: WIDTH] = x;
      Y_in[id*WIDTH +: WIDTH] = y;
      Req = '0;
      Req[id] = 1'b1;
      @(posedge Clk);
      #1;
      lat = 1;
      bad = (Busy !== 1'b1) || (Grant !== NREQ'(1) << id);
      while (Done !== 1'b1 && lat < 400) begin
         @(posedge Clk);
         #1;
         lat++;
         if (Busy !== 1'b1 || Grant !== NREQ'(1) << id) bad = 1'b1;
      end
      g = Gcd_out;
      gid = int'(Done_id);
      Req = '0;
      @(posedge Clk);
      #1;
   endtask
   initial begin
      int lat, gid, n;
      logic [7:0] g;
      bit bad, seen;
      int exp_rr [5] = '{0, 1, 2, 3, 0};
      vecs[0] = '{0, 8'd12,  8'd8,   8'd4,  4};
      vecs[1] = '{1, 8'd0,   8'd9,   8'd0,  2};
      vecs[2] = '{2, 8'd7,   8'd7,   8'd7,  2};
      vecs[3] = '{3, 8'd9,   8'd0,   8'd0,  2};
      vecs[4] = '{1, 8'd9,   8'd6,   8'd3,  4};
      vecs[5] = '{3, 8'd21,  8'd14,  8'd7,  4};
      vecs[6] = '{0, 8'd1,   8'd5,   8'd1,  6};
      vecs[7] = '{2, 8'd100, 8'd75,  8'd25, 5};
      X_in = '0;
      Y_in = '0;
      do_reset();
      chk("reset_grant", Grant, 0);
      chk("reset_busy", Busy, 0);
      chk("reset_done", Done, 0);
      chk("reset_gcd", Gcd_out, 0);
      chk("reset_id", Done_id, 0);
      for (int i = 0; i < 8; i++) begin
         run(vecs[i].id, vecs[i].x, vecs[i].y, lat, g, gid, bad);
         chk($sformatf("v%0d_gcd", i), g, vecs[i].g);
         chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_id", i), gid, vecs[i].id);
         chk($sformatf("v%0d_busy_grant", i), bad, 0);
      end
      repeat (3) @(posedge Clk);
      #1;
      chk("gcd_hold", Gcd_out, 25);
      chk("idle_busy", Busy, 0);
      chk("idle_grant", Grant, 0);
      // worst case
      run(0, 8'd255, 8'd1, lat, g, gid, bad);
      chk("worst_gcd", g, 1);
      chk("worst_lat", lat, 256);
      chk("worst_busy", bad, 0);
      // round robin with all requests held
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         X_in[i*WIDTH +: WIDTH] = 8'd6;
         Y_in[i*WIDTH +: WIDTH] = 8'd4;
      end
      Req = 4'b1111;
      bad = 1'b0;
      for (int t = 0; t < 5; t++) begin
         n = 0;
         do begin
            @(posedge Clk);
            #1;
            n++;
            if (!$onehot0(Grant)) bad = 1'b1;
         end while (Done !== 1'b1 && n < 50);
         chk($sformatf("rr%0d_id", t), Done_id, exp_rr[t]);
         chk($sformatf("rr%0d_gcd", t), Gcd_out, 2);
      end
      chk("rr_onehot", bad, 0);
      Req = '0;
      // abort of requester 0, pending requester 2 then wins
      do_reset();
      X_in[0 +: WIDTH] = 8'd255;
      Y_in[0 +: WIDTH] = 8'd1;
      X_in[2*WIDTH +: WIDTH] = 8'd9;
      Y_in[2*WIDTH +: WIDTH] = 8'd6;
      Req = 4'b0101;
      seen = 1'b0;
      repeat (10) begin
         @(posedge Clk);
         #1;
         if (Done) seen = 1'b1;
      end
      chk("abort_grant_before", Grant, 4'b0001);
      Req = 4'b0100;
      @(posedge Clk);
      #1;
      chk("abort_grant", Grant, 0);
      chk("abort_busy", Busy, 0);
      chk("abort_done", Done, 0);
      @(posedge Clk);
      #1;
      chk("abort_next_grant", Grant, 4'b0100);
      n = 0;
      while (Done !== 1'b1 && n < 50) begin
         @(posedge Clk);
         #1;
         n++;
      end
      chk("abort_next_id", Done_id, 2);
      chk("abort_next_gcd", Gcd_out, 3);
      chk("abort_no_done", seen, 0);
      Req = '0;
      // asynchronous reset in the middle of a calculation
      do_reset();
      X_in[WIDTH +: WIDTH] = 8'd255;
      Y_in[WIDTH +: WIDTH] = 8'd1;
      Req = 4'b0010;
      repeat (20) @(posedge Clk);
      #3;
      chk("pre_reset_busy", Busy, 1);
      Reset_n = 1'b0;
      #1;
      chk("mid_reset_grant", Grant, 0);
      chk("mid_reset_busy", Busy, 0);
      chk("mid_reset_done", Done, 0);
      chk("mid_reset_gcd", Gcd_out, 0);
      chk("mid_reset_id", Done_id, 0);
      Req = '0;
      @(negedge Clk) Reset_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(posedge Clk);
         #1;
         if (Done || Busy) seen = 1'b1;
      end
      chk("post_reset_quiet", seen, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
